// File: rtl/sync_gen.sv
// rtl/sync_gen.sv - raster timing generator: h/v counters, registered vs/hs/va/ha/de, pixel coords, frame/vblank ticks
// Every output is a flop fed from a decode of the current counters, so outputs lag the counters by one enabled cycle.
module sync_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic        o_sync_vs,
  output logic        o_sync_hs,
  output logic        o_sync_va,
  output logic        o_sync_ha,
  output logic        o_sync_de,
  output logic [10:0] o_cnt_x,
  output logic [9:0]  o_cnt_y,
  output logic        o_frame_start,
  output logic        o_vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        vs_q, vs_d, hs_q, hs_d, va_q, va_d, ha_q, ha_d, de_q, de_d;
  logic [10:0] cnt_x_q, cnt_x_d;
  logic [9:0]  cnt_y_q, cnt_y_d;
  logic        frame_start_q, frame_start_d, vblank_start_q, vblank_start_d;

  logic ha_dec, va_dec, de_dec;

  always_comb begin
    ha_dec = (h_cnt_q < H_ACT);
    va_dec = (v_cnt_q < V_ACT);
    de_dec = ha_dec & va_dec;

    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    vs_d           = vs_q;
    hs_d           = hs_q;
    va_d           = va_q;
    ha_d           = ha_q;
    de_d           = de_q;
    cnt_x_d        = cnt_x_q;
    cnt_y_d        = cnt_y_q;
    frame_start_d  = frame_start_q;
    vblank_start_d = vblank_start_q;

    // A stall freezes everything, so pulse outputs stretch across it.
    if (i_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end

      ha_d           = ha_dec;
      va_d           = va_dec;
      de_d           = de_dec;
      hs_d           = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs_d           = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      cnt_x_d        = de_dec ? h_cnt_q : '0;
      cnt_y_d        = de_dec ? v_cnt_q : '0;
      frame_start_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
      vblank_start_d = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      vs_q           <= 1'b1;
      hs_q           <= 1'b1;
      va_q           <= 1'b0;
      ha_q           <= 1'b0;
      de_q           <= 1'b0;
      cnt_x_q        <= '0;
      cnt_y_q        <= '0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      vs_q           <= vs_d;
      hs_q           <= hs_d;
      va_q           <= va_d;
      ha_q           <= ha_d;
      de_q           <= de_d;
      cnt_x_q        <= cnt_x_d;
      cnt_y_q        <= cnt_y_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign o_sync_vs      = vs_q;
  assign o_sync_hs      = hs_q;
  assign o_sync_va      = va_q;
  assign o_sync_ha      = ha_q;
  assign o_sync_de      = de_q;
  assign o_cnt_x        = cnt_x_q;
  assign o_cnt_y        = cnt_y_q;
  assign o_frame_start  = frame_start_q;
  assign o_vblank_start = vblank_start_q;

endmodule

// File: tb/tb_sync_gen.sv
// tb/tb_sync_gen.sv - directed bench for sync_gen: default-width lines on a short frame, plus a tiny 8x6 raster
module tb_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: XGA horizontal timing, vertical shortened to 8/1/2/1 (12 lines) to keep frames short.
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic        vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a;
  logic [10:0] cx_a;
  logic [9:0]  cy_a;

  sync_gen #(.H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
             .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
    .clk(clk), .rst(rst_a), .i_en(en_a),
    .o_sync_vs(vs_a), .o_sync_hs(hs_a), .o_sync_va(va_a), .o_sync_ha(ha_a),
    .o_sync_de(de_a), .o_cnt_x(cx_a), .o_cnt_y(cy_a),
    .o_frame_start(fs_a), .o_vblank_start(vb_a)
  );

  // Instance B: H 4/1/2/1, V 3/1/1/1 -> 8x6 raster.
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic        vs_b, hs_b, va_b, ha_b, de_b, fs_b, vb_b;
  logic [10:0] cx_b;
  logic [9:0]  cy_b;

  sync_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
             .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_b (
    .clk(clk), .rst(rst_b), .i_en(en_b),
    .o_sync_vs(vs_b), .o_sync_hs(hs_b), .o_sync_va(va_b), .o_sync_ha(ha_b),
    .o_sync_de(de_b), .o_cnt_x(cx_b), .o_cnt_y(cy_b),
    .o_frame_start(fs_b), .o_vblank_start(vb_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves instance A one cycle after release: the sample showing pixel (0,0).
  task automatic reset_a;
    rst_a = 1'b1;
    en_a  = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [6:0] flags;
    rst_a = 1'b1;
    en_a  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      flags = {vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a};
      n_checks++;
      if (flags !== 7'b1100000 || cx_a !== 11'd0 || cy_a !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: flags %b x %0d y %0d, want flags 1100000 x 0 y 0",
                 c, flags, cx_a, cy_a);
      end
    end
    rst_a = 1'b0;
    tick();
    flags = {vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a};
    n_checks++;
    if (flags !== 7'b1111110 || cx_a !== 11'd0 || cy_a !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release: flags %b x %0d y %0d, want flags 1111110 x 0 y 0",
               flags, cx_a, cy_a);
    end
  endtask

  task automatic test_line_timing;
    int de_fall, hs_fall, hs_rise, de_rise;
    de_fall = -1; hs_fall = -1; hs_rise = -1; de_rise = -1;
    reset_a();
    for (int k = 1; k <= 1400 && de_rise < 0; k++) begin
      tick();
      if (de_fall < 0 && !de_a) de_fall = k;
      if (hs_fall < 0 && !hs_a) hs_fall = k;
      if (hs_fall >= 0 && hs_rise < 0 && hs_a) hs_rise = k;
      if (de_fall >= 0 && de_rise < 0 && de_a) de_rise = k;
    end
    n_checks++;
    if (de_fall != 1024) begin
      n_fail++; $display("FAIL line_de_high: got %0d want 1024", de_fall);
    end
    n_checks++;
    if (hs_fall != 1048) begin
      n_fail++; $display("FAIL line_hs_fall: got %0d want 1048", hs_fall);
    end
    n_checks++;
    if (hs_rise - hs_fall != 136) begin
      n_fail++; $display("FAIL line_hs_low: got %0d want 136", hs_rise - hs_fall);
    end
    n_checks++;
    if (de_rise != 1344) begin
      n_fail++; $display("FAIL line_period: got %0d want 1344", de_rise);
    end
  endtask

  task automatic test_frame;
    int de_cnt, fs_cnt, vb_cnt, vb_idx, vs_low, vs_first, bad;
    de_cnt = 0; fs_cnt = 0; vb_cnt = 0; vb_idx = -1; vs_low = 0; vs_first = -1; bad = 0;
    reset_a();
    for (int k = 0; k < 16128; k++) begin
      if (de_a) de_cnt++;
      if (fs_a) fs_cnt++;
      if (vb_a) begin
        vb_cnt++;
        if (vb_idx < 0) vb_idx = k;
      end
      if (!vs_a) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if ((vs_a & hs_a & va_a & ha_a) !== de_a) bad++;
      tick();
    end
    n_checks++;
    if (de_cnt != 8192) begin
      n_fail++; $display("FAIL frame_de_count: got %0d want 8192", de_cnt);
    end
    n_checks++;
    if (fs_cnt != 1) begin
      n_fail++; $display("FAIL frame_fs_count: got %0d want 1", fs_cnt);
    end
    n_checks++;
    if (vb_cnt != 1 || vb_idx != 10752) begin
      n_fail++; $display("FAIL frame_vblank: got count %0d at %0d want 1 at 10752", vb_cnt, vb_idx);
    end
    n_checks++;
    if (vs_low != 2688 || vs_first != 12096) begin
      n_fail++; $display("FAIL frame_vs: got %0d low from %0d want 2688 from 12096", vs_low, vs_first);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL frame_all_high_eq_de: got %0d violations want 0", bad);
    end
    n_checks++;
    if (fs_a !== 1'b1 || cx_a !== 11'd0 || cy_a !== 10'd0) begin
      n_fail++; $display("FAIL frame_next_start: got fs %b x %0d y %0d want fs 1 x 0 y 0", fs_a, cx_a, cy_a);
    end
  endtask

  task automatic test_small_config;
    int h, v, p;
    logic [27:0] got, exp;
    logic e_ha, e_va, e_de;
    rst_b = 1'b1;
    en_b  = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    for (int k = 0; k < 96; k++) begin
      p = k % 48;
      h = p % 8;
      v = p / 8;
      e_ha = (h < 4);
      e_va = (v < 3);
      e_de = e_ha & e_va;
      exp = {(v != 4), !(h == 5 || h == 6), e_va, e_ha, e_de, (p == 0), (p == 24),
             e_de ? 11'(h) : 11'd0, e_de ? 10'(v) : 10'd0};
      got = {vs_b, hs_b, va_b, ha_b, de_b, fs_b, vb_b, cx_b, cy_b};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL small_wave k=%0d: got %b want %b", k, got, exp);
      end
      tick();
    end
    en_b = 1'b0;
  endtask

  task automatic test_stall;
    int t, de_rise;
    logic [27:0] snap, cur;
    logic seen_fall;
    reset_a();
    t = 0;
    while (cx_a != 11'd10 && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (cx_a !== 11'd10) begin
      n_fail++;
      $display("FAIL stall_reach_x10: got %0d want 10", cx_a);
      return;
    end
    snap = {vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a, cx_a, cy_a};
    en_a = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      t++;
      cur = {vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a, cx_a, cy_a};
      n_checks++;
      if (cur !== snap) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got %b want %b", c, cur, snap);
      end
    end
    en_a = 1'b1;
    tick();
    t++;
    n_checks++;
    if (cx_a !== 11'd11 || de_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume: got x %0d de %b want x 11 de 1", cx_a, de_a);
    end
    de_rise = -1;
    seen_fall = 1'b0;
    while (de_rise < 0 && t < 1500) begin
      tick();
      t++;
      if (!de_a) seen_fall = 1'b1;
      else if (seen_fall) de_rise = t;
    end
    n_checks++;
    if (de_rise != 1351) begin
      n_fail++;
      $display("FAIL stall_line_period: got %0d want 1351", de_rise);
    end
  endtask

  task automatic test_mid_reset;
    int t, vs_low, fs_cnt;
    logic [6:0] flags;
    reset_a();
    t = 0;
    while (!(de_a && cy_a == 10'd4) && t < 8000) begin
      tick();
      t++;
    end
    repeat (100) tick();
    n_checks++;
    if (!(va_a === 1'b1 && cy_a == 10'd4)) begin
      n_fail++;
      $display("FAIL mid_reach_line4: got va %b y %0d want va 1 y 4", va_a, cy_a);
    end
    rst_a = 1'b1;
    tick();
    flags = {vs_a, hs_a, va_a, ha_a, de_a, fs_a, vb_a};
    n_checks++;
    if (flags !== 7'b1100000 || cx_a !== 11'd0 || cy_a !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: flags %b x %0d y %0d want 1100000 x 0 y 0", flags, cx_a, cy_a);
    end
    rst_a = 1'b0;
    tick();
    n_checks++;
    if (fs_a !== 1'b1 || de_a !== 1'b1 || cx_a !== 11'd0 || cy_a !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_restart: fs %b de %b x %0d y %0d want fs 1 de 1 x 0 y 0", fs_a, de_a, cx_a, cy_a);
    end
    vs_low = 0;
    fs_cnt = 0;
    for (int k = 0; k < 12096; k++) begin
      if (!vs_a) vs_low++;
      if (fs_a) fs_cnt++;
      tick();
    end
    n_checks++;
    if (vs_low != 0 || fs_cnt != 1) begin
      n_fail++;
      $display("FAIL mid_no_residual: vs low %0d fs %0d want vs low 0 fs 1", vs_low, fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_small_config();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
